// File: rtl/punc_control_hs_if.sv
// Memory-port handshake bundle between the PUnC controller and a variable-latency memory.
// The controller owns the request side; the memory answers with mem_ready.
interface punc_control_hs_if;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_addr_sel;
  logic       mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/punc_control_hs.sv
// PUnC LC3 control FSM driving a ready/valid memory port, with a per-access
// timeout watchdog, sticky HALT/FAULT states and a per-instruction retire pulse.
module punc_control_hs #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              ir,
  input  logic                     n,
  input  logic                     z,
  input  logic                     p,
  punc_control_hs_if.master        mem,
  output logic                     mdr_ld,
  output logic                     ir_ld,
  output logic                     pc_ld,
  output logic [1:0]               pc_sel,
  output logic                     rf_w_en,
  output logic [1:0]               rf_w_sel,
  output logic                     rf_w_r7,
  output logic                     nzp_ld,
  output logic                     clr,
  output logic                     retired,
  output logic                     halted,
  output logic                     fault,
  output logic [3:0]               state_o
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM1   = 4'd4,
    S_MEM2   = 4'd5,
    S_WB     = 4'd6,
    S_HALT   = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_EA  = 2'd1;
  localparam logic [1:0] ADDR_MDR = 2'd2;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_OFF9  = 2'd1;
  localparam logic [1:0] PC_BASER = 2'd2;
  localparam logic [1:0] PC_OFF11 = 2'd3;

  localparam logic [1:0] RFW_ALU = 2'd0;
  localparam logic [1:0] RFW_MDR = 2'd1;
  localparam logic [1:0] RFW_PC  = 2'd2;

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WDOG_EN = (TIMEOUT_CYCLES != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;

  logic [3:0]         opcode;
  logic               br_taken;
  logic [CNT_W-1:0]   wait_inc;
  logic               wait_expired;
  logic               req, we;
  logic [1:0]         addr_sel;
  logic               unused_ir;

  assign opcode       = ir[15:12];
  assign br_taken     = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
  assign wait_inc     = wait_q + CNT_W'(1);
  // The cycle that would bring the count to the limit is the last one allowed.
  assign wait_expired = WDOG_EN && (wait_inc == TO_CNT);
  assign unused_ir    = ^ir[8:0];

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    req      = 1'b0;
    we       = 1'b0;
    addr_sel = ADDR_PC;
    mdr_ld   = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    pc_sel   = PC_INC;
    rf_w_en  = 1'b0;
    rf_w_sel = RFW_ALU;
    rf_w_r7  = 1'b0;
    nzp_ld   = 1'b0;
    clr      = 1'b0;
    retired  = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    state_o  = 4'd0;

    // Reset silences every output, including a request that was in flight.
    if (!rst) begin
      state_o = state_q;
      case (state_q)
        S_INIT: begin
          clr     = 1'b1;
          state_d = S_FETCH;
        end

        S_FETCH: begin
          req      = 1'b1;
          addr_sel = ADDR_PC;
          if (mem.mem_ready) begin
            ir_ld   = 1'b1;
            state_d = S_DECODE;
          end else if (wait_expired) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_inc;
          end
        end

        S_DECODE: begin
          pc_ld  = 1'b1;
          pc_sel = PC_INC;
          if (opcode == OP_TRAP)                          state_d = S_HALT;
          else if (opcode == OP_RTI || opcode == OP_RES)  state_d = S_FAULT;
          else                                            state_d = S_EXEC;
        end

        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
              rf_w_en  = 1'b1;
              rf_w_sel = RFW_ALU;
              nzp_ld   = 1'b1;
              retired  = 1'b1;
            end
            OP_BR: begin
              pc_ld   = br_taken;
              pc_sel  = br_taken ? PC_OFF9 : PC_INC;
              retired = 1'b1;
            end
            OP_JMP: begin
              pc_ld   = 1'b1;
              pc_sel  = PC_BASER;
              retired = 1'b1;
            end
            // Link and jump share the cycle; the PC mux reads BaseR before R7 is written.
            OP_JSR: begin
              rf_w_en  = 1'b1;
              rf_w_sel = RFW_PC;
              rf_w_r7  = 1'b1;
              pc_ld    = 1'b1;
              pc_sel   = ir[11] ? PC_OFF11 : PC_BASER;
              retired  = 1'b1;
            end
            OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: begin
              state_d = S_MEM1;
            end
            default: begin
              state_d = S_FAULT;
            end
          endcase
        end

        S_MEM1: begin
          req      = 1'b1;
          addr_sel = ADDR_EA;
          we       = (opcode == OP_ST) || (opcode == OP_STR);
          if (mem.mem_ready) begin
            case (opcode)
              OP_LD, OP_LDR: begin
                mdr_ld  = 1'b1;
                state_d = S_WB;
              end
              OP_LDI, OP_STI: begin
                mdr_ld  = 1'b1;
                state_d = S_MEM2;
              end
              default: begin
                retired = 1'b1;
                state_d = S_FETCH;
              end
            endcase
          end else if (wait_expired) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_inc;
          end
        end

        S_MEM2: begin
          req      = 1'b1;
          addr_sel = ADDR_MDR;
          we       = (opcode == OP_STI);
          if (mem.mem_ready) begin
            if (opcode == OP_LDI) begin
              mdr_ld  = 1'b1;
              state_d = S_WB;
            end else begin
              retired = 1'b1;
              state_d = S_FETCH;
            end
          end else if (wait_expired) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_inc;
          end
        end

        S_WB: begin
          rf_w_en  = 1'b1;
          rf_w_sel = RFW_MDR;
          nzp_ld   = 1'b1;
          retired  = 1'b1;
          state_d  = S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
        end

        S_FAULT: begin
          fault = 1'b1;
        end

        default: begin
          state_d = S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control_hs.sv
// Directed bench for punc_control_hs: an instruction-level schedule model predicts every
// output cycle, and a few hand-computed literals pin cycle counts and sticky states.
module tb_punc_control_hs;
  localparam int TO = 4;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [1:0] asel;
    logic       mdr;
    logic       irl;
    logic       pcl;
    logic [1:0] pcs;
    logic       rfe;
    logic [1:0] rfs;
    logic       r7;
    logic       nzl;
    logic       clr;
    logic       ret;
    logic       hlt;
    logic       flt;
    logic [3:0] st;
  } ovec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir  = 16'h0000;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  logic        mdr_ld, ir_ld, pc_ld, rf_w_en, rf_w_r7, nzp_ld, clr, retired, halted, fault;
  logic [1:0]  pc_sel, rf_w_sel;
  logic [3:0]  state_o;

  int    n_cmp = 0;
  int    n_bad = 0;
  ovec_t exp_q[$];
  string tag_q[$];
  ovec_t act_log[$];

  punc_control_hs_if hs();

  punc_control_hs #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem(hs),
    .mdr_ld(mdr_ld), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_sel(pc_sel),
    .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .rf_w_r7(rf_w_r7), .nzp_ld(nzp_ld),
    .clr(clr), .retired(retired), .halted(halted), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic ovec_t sample();
    ovec_t a;
    a.req = hs.mem_req;  a.we = hs.mem_we;  a.asel = hs.mem_addr_sel;
    a.mdr = mdr_ld;      a.irl = ir_ld;     a.pcl = pc_ld;   a.pcs = pc_sel;
    a.rfe = rf_w_en;     a.rfs = rf_w_sel;  a.r7 = rf_w_r7;  a.nzl = nzp_ld;
    a.clr = clr;         a.ret = retired;   a.hlt = halted;  a.flt = fault;
    a.st  = state_o;
    return a;
  endfunction

  always @(negedge clk) begin : compare
    ovec_t a, e;
    string t;
    a = sample();
    act_log.push_back(a);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s @%0t: outputs %h, required %h", t, $time, a, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input logic rdy, input ovec_t e, input string tag);
    hs.mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic int count_st(input logic [3:0] s);
    int c = 0;
    foreach (act_log[i]) if (act_log[i].st == s) c++;
    return c;
  endfunction

  function automatic int count_bit(input int f);
    int c = 0;
    foreach (act_log[i]) begin
      case (f)
        0:       c += int'(act_log[i].req);
        1:       c += int'(act_log[i].irl);
        2:       c += int'(act_log[i].ret);
        3:       c += int'(act_log[i].we);
        default: c += int'(act_log[i].clr);
      endcase
    end
    return c;
  endfunction

  // One memory access: `waits` idle cycles then the ready cycle, unless the watchdog fires first.
  task automatic access(input logic [3:0] s, input logic [1:0] sel, input logic we,
                        input logic ldir, input logic ldmdr, input logic ret,
                        input int waits, output bit to);
    ovec_t e;
    to = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      if (w == TO) begin
        to = 1'b1;
        break;
      end
      e = '0;
      e.req = 1'b1; e.we = we; e.asel = sel; e.st = s;
      if (w == waits) begin
        e.irl = ldir; e.mdr = ldmdr; e.ret = ret;
      end
      step(w == waits, e, $sformatf("acc_s%0d_w%0d", s, w));
    end
  endtask

  task automatic terminal(input logic [3:0] code);
    ovec_t e;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      e.st = code; e.hlt = (code == 4'd7); e.flt = (code == 4'd8);
      step(i % 2 == 0, e, (code == 4'd7) ? "halt" : "fault");
    end
  endtask

  task automatic do_reset(input int k);
    ovec_t e;
    rst = 1'b1;
    for (int i = 0; i < k; i++) step(1'b1, '0, "reset");
    rst = 1'b0;
    e = '0;
    e.clr = 1'b1;
    step(1'b1, e, "init");
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [2:0] nzp,
                           input int wf, input int w1, input int w2);
    ovec_t e;
    bit to;
    logic [3:0] op;
    logic is_ld, is_ldi, is_st, is_sti;
    ir = instr;
    {n, z, p} = nzp;
    op = instr[15:12];
    access(4'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, wf, to);
    if (to) begin terminal(4'd8); return; end
    e = '0; e.st = 4'd2; e.pcl = 1'b1;
    step(1'b1, e, "decode");
    if (op == 4'hF) begin terminal(4'd7); return; end
    if (op == 4'h8 || op == 4'hD) begin terminal(4'd8); return; end
    e = '0; e.st = 4'd3;
    case (op)
      4'h1, 4'h5, 4'h9, 4'hE: begin e.rfe = 1'b1; e.nzl = 1'b1; e.ret = 1'b1; end
      4'h0: begin
        if ((nzp & instr[11:9]) != 3'b000) begin e.pcl = 1'b1; e.pcs = 2'd1; end
        e.ret = 1'b1;
      end
      4'hC: begin e.pcl = 1'b1; e.pcs = 2'd2; e.ret = 1'b1; end
      4'h4: begin
        e.rfe = 1'b1; e.rfs = 2'd2; e.r7 = 1'b1; e.pcl = 1'b1;
        e.pcs = instr[11] ? 2'd3 : 2'd2; e.ret = 1'b1;
      end
      default: ;
    endcase
    step(1'b1, e, "exec");
    is_ld  = (op == 4'h2) || (op == 4'h6);
    is_ldi = (op == 4'hA);
    is_st  = (op == 4'h3) || (op == 4'h7);
    is_sti = (op == 4'hB);
    if (!(is_ld || is_ldi || is_st || is_sti)) return;
    access(4'd4, 2'd1, is_st, 1'b0, !is_st, is_st, w1, to);
    if (to) begin terminal(4'd8); return; end
    if (is_ldi || is_sti) begin
      access(4'd5, 2'd2, is_sti, 1'b0, is_ldi, is_sti, w2, to);
      if (to) begin terminal(4'd8); return; end
    end
    if (is_ld || is_ldi) begin
      e = '0; e.st = 4'd6; e.rfe = 1'b1; e.rfs = 2'd1; e.nzl = 1'b1; e.ret = 1'b1;
      step(1'b1, e, "wb");
    end
  endtask

  initial begin : main
    ovec_t e;
    bit to;
    hs.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset release with zero-wait memory, then ADD.
    act_log.delete();
    do_reset(2);
    run_instr(16'h1261, 3'b000, 0, 0, 0);
    check("rst_st_init",  int'(act_log[2].st), 0);
    check("rst_st_fetch", int'(act_log[3].st), 1);
    check("rst_st_dec",   int'(act_log[4].st), 2);
    check("rst_st_exec",  int'(act_log[5].st), 3);
    check("rst_clr_once", count_bit(4), 1);
    check("rst_fetch_req", int'(act_log[3].req), 1);
    check("rst_fetch_sel", int'(act_log[3].asel), 0);

    // FETCH with three wait cycles.
    act_log.delete();
    run_instr(16'h1261, 3'b000, 3, 0, 0);
    check("wait_req_cycles", count_bit(0), 4);
    check("wait_irld_count", count_bit(1), 1);
    check("wait_irld_4th",   int'(act_log[3].irl), 1);
    check("wait_ret_count",  count_bit(2), 1);
    check("wait_ret_6th",    int'(act_log[5].ret), 1);

    // LDI zero-wait.
    act_log.delete();
    run_instr(16'hA200, 3'b000, 0, 0, 0);
    check("ldi_len",      act_log.size(), 6);
    check("ldi_mem2_sel", int'(act_log[4].asel), 2);
    check("ldi_wb_ret",   int'(act_log[5].ret), 1);

    // STI zero-wait.
    act_log.delete();
    run_instr(16'hB200, 3'b000, 0, 0, 0);
    check("sti_we_count", count_bit(3), 1);
    check("sti_we_mem2",  int'(act_log[4].we), 1);
    check("sti_ret_mem2", int'(act_log[4].ret), 1);

    // Branches and jumps.
    act_log.delete();
    run_instr(16'h0402, 3'b010, 0, 0, 0);
    check("brz_taken_pcl", int'(act_log[2].pcl), 1);
    check("brz_taken_pcs", int'(act_log[2].pcs), 1);
    act_log.delete();
    run_instr(16'h0402, 3'b100, 0, 0, 0);
    check("brz_nt_pcl", int'(act_log[2].pcl), 0);
    check("brz_nt_ret", int'(act_log[2].ret), 1);
    run_instr(16'h0000, 3'b111, 0, 0, 0);
    run_instr(16'h0A00, 3'b001, 0, 0, 0);
    act_log.delete();
    run_instr(16'h40C0, 3'b000, 0, 0, 0);
    check("jsrr_r7",  int'(act_log[2].r7), 1);
    check("jsrr_rfs", int'(act_log[2].rfs), 2);
    check("jsrr_pcs", int'(act_log[2].pcs), 2);
    run_instr(16'h4805, 3'b000, 0, 0, 0);
    run_instr(16'hC1C0, 3'b000, 0, 0, 0);
    run_instr(16'h927F, 3'b000, 1, 0, 0);
    run_instr(16'h5262, 3'b000, 0, 0, 0);
    run_instr(16'hE005, 3'b000, 0, 0, 0);
    run_instr(16'h2205, 3'b000, 0, 2, 0);
    run_instr(16'h6041, 3'b000, 0, TO - 1, 0);
    run_instr(16'h3205, 3'b000, 0, 1, 0);
    run_instr(16'h7041, 3'b000, 2, 0, 0);
    run_instr(16'hA200, 3'b000, 0, 1, TO - 1);
    run_instr(16'hB200, 3'b000, 1, 0, 2);

    // Watchdog in MEM1 of LD.
    act_log.delete();
    run_instr(16'h2000, 3'b000, 0, 100, 0);
    check("to_mem1_cycles", count_st(4'd4), TO);
    check("to_pre_fault",   int'(act_log[6].flt), 0);
    check("to_fault",       int'(act_log[7].flt), 1);
    check("to_fault_stick", int'(act_log[9].flt), 1);
    do_reset(1);

    // Watchdog in FETCH.
    act_log.delete();
    run_instr(16'h1261, 3'b000, 50, 0, 0);
    check("tof_fetch_cycles", count_st(4'd1), TO);
    check("tof_state", int'(act_log[4].st), 8);
    do_reset(1);

    // Illegal opcodes and HALT.
    act_log.delete();
    run_instr(16'hD000, 3'b000, 0, 0, 0);
    check("op1101_fault", int'(act_log[2].flt), 1);
    check("op1101_state", int'(act_log[2].st), 8);
    do_reset(1);
    run_instr(16'h8000, 3'b000, 0, 0, 0);
    do_reset(1);
    act_log.delete();
    run_instr(16'hF025, 3'b000, 0, 0, 0);
    check("halt_flag",   int'(act_log[2].hlt), 1);
    check("halt_sticky", int'(act_log[4].hlt), 1);
    do_reset(1);

    // Reset in the middle of a MEM1 wait.
    act_log.delete();
    ir = 16'h2000;
    {n, z, p} = 3'b000;
    access(4'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, to);
    e = '0; e.st = 4'd2; e.pcl = 1'b1;
    step(1'b1, e, "decode");
    e = '0; e.st = 4'd3;
    step(1'b1, e, "exec");
    e = '0; e.req = 1'b1; e.asel = 2'd1; e.st = 4'd4;
    step(1'b0, e, "mem1_hold");
    do_reset(1);
    check("mid_req_before", int'(act_log[3].req), 1);
    check("mid_req_rst",    int'(act_log[4].req), 0);
    check("mid_init_state", int'(act_log[5].st), 0);
    check("mid_init_clr",   int'(act_log[5].clr), 1);
    run_instr(16'h1261, 3'b000, 0, 0, 0);

    check("exp_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

endmodule

// File: doc/punc_control_hs.md
Name: punc_control_hs

Overview:
- Next-generation PUnC LC3 control FSM with a ready/valid handshake to variable-latency memory, replacing fixed single-cycle memory timing.
- Sequences fetch, decode, execute, memory (one or two accesses) and write-back.
- Adds a parametrised per-access timeout watchdog, a sticky fault state for illegal opcodes and timeouts, and a per-instruction retire pulse.
- Sits between the PUnC datapath (IR, NZP, PC, RF, MDR) and the memory port.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles per memory access before fault; 0 disables the watchdog.
- CNT_W, 8: wait-counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ir  in  16  instruction register contents.
- n, z, p  in  1 each  condition codes from datapath.
- mem_ready  in  1  memory completes the current access in the cycle it is high while mem_req is high.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier, valid while mem_req is high.
- mem_addr_sel  out  2  address source: 0=PC, 1=EA, 2=MDR.
- mdr_ld  out  1  capture read data into MDR.
- ir_ld  out  1  capture read data into IR.
- pc_ld  out  1  load PC.
- pc_sel  out  2  PC source: 0=PC+1, 1=PC+off9, 2=BaseR, 3=PC+off11.
- rf_w_en  out  1  register-file write enable.
- rf_w_sel  out  2  RF write data source: 0=ALU, 1=MDR, 2=PC.
- rf_w_r7  out  1  force RF write address to R7.
- nzp_ld  out  1  load condition codes.
- clr  out  1  clear PC, IR, NZP and RF.
- retired  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- state_o  out  4  current state code, for debug.

Behaviour:
- States: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM1=4, MEM2=5, WB=6, HALT=7, FAULT=8.
- Reset:
  - rst high forces INIT at the next edge from any state, including mid-access; any outstanding request is dropped.
  - Every output defaults to 0 except in the cases listed below; all outputs are 0 during reset apart from those INIT drives.
- INIT: clr=1 for one cycle -> FETCH.
- Wait counter:
  - Cleared on entry to each request state (FETCH, MEM1, MEM2); increments each cycle the state is held without mem_ready.
  - With TIMEOUT_CYCLES>0, reaching TIMEOUT_CYCLES -> FAULT.
  - mem_ready high in the same cycle takes priority over timeout.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0.
  - mem_ready: ir_ld=1 -> DECODE; otherwise hold.
- DECODE: pc_ld=1, pc_sel=0.
  - opcode 1111 -> HALT.
  - 1000 or 1101 -> FAULT.
  - all others -> EXEC.
- EXEC (combinational on ir[15:12]):
  - ADD/AND/NOT/LEA: rf_w_en=1, rf_w_sel=0, nzp_ld=1 -> FETCH, retired=1.
  - BR: if (n&ir[11])|(z&ir[10])|(p&ir[9]), pc_ld=1, pc_sel=1; always -> FETCH, retired=1. BR with nzp=000 is a NOP.
  - JMP/RET: pc_ld=1, pc_sel=2 -> FETCH, retired=1.
  - JSR/JSRR, single cycle:
    - rf_w_en=1, rf_w_sel=2, rf_w_r7=1.
    - pc_ld=1, pc_sel = ir[11] ? 3 : 2.
    - The PC load uses the pre-write BaseR, so JSRR R7 jumps to the old R7.
    - -> FETCH, retired=1.
  - LD/LDR/LDI/ST/STR/STI -> MEM1.
- MEM1: mem_req=1, mem_addr_sel=1; mem_we=1 for ST/STR only. On mem_ready:
  - LD/LDR: mdr_ld=1 -> WB.
  - LDI/STI: mdr_ld=1 -> MEM2.
  - ST/STR -> FETCH, retired=1.
- MEM2: mem_req=1, mem_addr_sel=2; mem_we=1 for STI. On mem_ready:
  - LDI: mdr_ld=1 -> WB.
  - STI -> FETCH, retired=1.
- WB: rf_w_en=1, rf_w_sel=1, nzp_ld=1 -> FETCH, retired=1.
- HALT and FAULT are terminal until rst; halted/fault are high throughout.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable from assertion until the mem_ready cycle.
  - mem_ready while mem_req is low is ignored.
  - Back-to-back accesses are legal; mem_req may stay high across a state change.
  - Zero-wait memory (mem_ready tied high) gives: ALU instruction 3 cycles; LD 5; LDI 6; ST 4.

Test Plan:
- Reset: rst for 2 cycles then release with mem_ready=1 → INIT shows clr=1 for exactly one cycle; FETCH asserts mem_req, mem_addr_sel=0; state_o sequence 0,1,2,3.
- Wait states: ADD R1,R1,#1, mem_ready delayed 3 cycles in FETCH → mem_req held high 4 cycles; ir_ld only in the 4th; retired one pulse; 6 cycles from FETCH entry to retire.
- LDI: mem_ready=1 → FETCH, DECODE, EXEC, MEM1 (mdr_ld, sel 1), MEM2 (mdr_ld, sel 2), WB (rf_w_sel=1, nzp_ld) → 6 cycles.
- STI: mem_ready=1 → mem_we=1 only in MEM2; retired pulses when leaving MEM2.
- Branches: BRz with z=1 → pc_ld=1, pc_sel=1 in EXEC; same opcode with z=0,n=1 → pc_ld=0, retired=1. JSRR R3 → rf_w_r7=1, rf_w_sel=2, pc_sel=2 in the same cycle.
- Faults: with TIMEOUT_CYCLES=4, hold mem_ready=0 in MEM1 of LD → FAULT after exactly 4 wait cycles, fault=1 sticky; opcode 1101 → FAULT from DECODE; opcode 1111 → halted=1; rst asserted mid-MEM1 → INIT next cycle, mem_req=0.
